acc_term_sequencer: RTL and testbench
=====================================

Name: acc_term_sequencer

Overview:
- Upstream control stage for the accumulator in the reservoir dot-product path.
- Takes a start command with a term count N, then accepts N signed terms over a valid/ready stream.
- Drives the accumulator's init/valid/sub/data inputs so that exactly those N terms are summed from zero.
- Pulses oDone in the first cycle the accumulator output holds the final sum.

Parameters:
- WIDTH_IN, 16, term/data width; matches accumulator WIDTH_IN.
- WIDTH_LEN, 10, width of term count; max N = 2^WIDTH_LEN-1.
- ACC_LAT, 2, cycles from the last accumulator-input cycle to the result being visible on the accumulator output.

Ports:
- iCLK  in  1  clock.
- iRST_n  in  1  asynchronous active-low reset.
- iStart  in  1  start pulse; sampled only in IDLE.
- iLen  in  WIDTH_LEN  term count N; captured with iStart.
- iAbort  in  1  abandon the current frame; no oDone is produced.
- oBusy  out  1  high in RUN or DRAIN.
- iTermValid  in  1  term available.
- iTermData  in  WIDTH_IN  term magnitude/value, forwarded unchanged.
- iTermNeg  in  1  subtract this term.
- iTermZero  in  1  term consumed but contributes nothing (zero weight).
- oTermReady  out  1  high in RUN only.
- oAccInit  out  1  to accumulator iInit.
- oAccValid  out  1  to accumulator iValid.
- oAccSub  out  1  to accumulator iSub.
- oAccData  out  WIDTH_IN  to accumulator iData.
- oDone  out  1  one-cycle pulse: accumulator output is final.
- oCount  out  WIDTH_LEN  terms remaining in the frame.

Behaviour:
- Reset (async assert, sync release): state IDLE, oCount=0, init-pending=0, drain counter=0. oTermReady, oAccInit, oAccValid, oAccSub, oDone and oBusy are 0. oAccData=0.
- The accumulator-side outputs are combinational from state and term inputs; the accumulator registers them itself.
- Handshake: a term is consumed on any edge where iTermValid & oTermReady.
- oAccValid = consume & !iTermZero. oAccSub = oAccValid & iTermNeg. oAccData = oAccValid ? iTermData : 0.
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - on iStart: oCount<=iLen and init-pending<=1.
  - If iLen!=0, go to RUN. If iLen==0, go to DRAIN with drain counter=ACC_LAT.
- IDLE, iLen==0: oAccInit is high in the start cycle so the accumulator clears to 0. oDone follows exactly as for a normal frame.
- RUN:
  - oAccInit = init-pending. It stays high every cycle until and including the first consume, then init-pending<=0.
  - Init held while iTermValid is low only loads 0 into the accumulator, which is harmless.
  - Each consume decrements oCount. On the consume with oCount==1, go to DRAIN with drain counter=ACC_LAT.
- DRAIN: the drain counter decrements each cycle. oDone=1 in the cycle the counter reads 1, then go to IDLE.
- Timing, N≥1: last consume at edge T. The accumulator registers data at T and the sum at T+1. oDone is high during cycle T+1..T+2 and aligned with the valid result.
- Cycle after oDone: back in IDLE, so iStart may be asserted in that cycle. Back-to-back frames therefore have a 1-cycle IDLE gap minimum.
- iStart outside IDLE: ignored.
- iAbort (any state except IDLE) → IDLE next edge.
  - The accumulator contents become don't-care; no oDone.
  - iAbort takes priority over a simultaneous consume; that term is not counted.
  - The next frame's init clears the accumulator.
- Reset mid-frame: same as abort, asynchronously; all outputs 0 immediately.
- Width: the sequencer performs no arithmetic on data. Sign handling and growth are the accumulator's job (WIDTH_OUT).

Decomposition:
- Shared package (hrc_pkg):
  - FSM state enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - Default ACC_LAT constant = 2, shared with the accumulator instantiation.
- No sub-module. A thin top-level wrapper pairing acc_term_sequencer with the accumulator (acc_term_unit) is expected for integration tests.

Test Plan:
- iLen=3, terms 5,7,-(3) (iTermNeg=1 on the third), iTermValid continuous → oDone 2 cycles after the 3rd consume; accumulator out = 9; oCount 3→2→1→0.
- iLen=4, iTermValid gaps (1,0,0,1,1,0,1), values 1,2,3,4 → oAccInit high through the first consume only; result 10; oDone 2 cycles after the 4th consume.
- iLen=3 with iTermZero on the middle term (data 100), terms 6,100,6 → result 12; oAccValid low on the middle consume.
- iLen=0 → oAccInit pulse in the start cycle; oDone 2 cycles later; result 0 even if the previous sum was 0x7FFF.
- Frame 1: iLen=5, iAbort after 2 terms → no oDone; oBusy falls next cycle. Frame 2: iLen=2, terms 1,1 → result 2.
- iRST_n low mid-RUN (oCount=3) → all outputs 0 asynchronously. After release, iStart in RUN is ignored until a fresh IDLE start; a frame with iLen=1, term 8 → result 8.

Source files
------------

// File: rtl/hrc_pkg.sv
// Shared definitions for the reservoir dot-product accumulator path:
// sequencer FSM encoding and the default accumulator latency.
package hrc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // Must match the pipeline depth of the acc_term_unit it is paired with.
    localparam int ACC_LAT_DEFAULT = 2;

endpackage

// File: rtl/acc_term_sequencer_if.sv
// Valid/ready term stream feeding the accumulator sequencer.
// master = term source, slave = sequencer.
interface acc_term_sequencer_if #(
    parameter int WIDTH_IN = 16
);
    logic                iTermValid;
    logic [WIDTH_IN-1:0] iTermData;
    logic                iTermNeg;
    logic                iTermZero;
    logic                oTermReady;

    modport master (
        output iTermValid, iTermData, iTermNeg, iTermZero,
        input  oTermReady
    );

    modport slave (
        input  iTermValid, iTermData, iTermNeg, iTermZero,
        output oTermReady
    );
endinterface

// File: rtl/acc_term_sequencer.sv
// Control stage ahead of the dot-product accumulator: runs exactly N terms
// into a freshly initialised accumulator and flags when its output is final.
module acc_term_sequencer
    import hrc_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_LEN = 10,
    parameter int ACC_LAT   = ACC_LAT_DEFAULT
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic                 iStart,
    input  logic [WIDTH_LEN-1:0] iLen,
    input  logic                 iAbort,
    output logic                 oBusy,
    acc_term_sequencer_if.slave  term,
    output logic                 oAccInit,
    output logic                 oAccValid,
    output logic                 oAccSub,
    output logic [WIDTH_IN-1:0]  oAccData,
    output logic                 oDone,
    output logic [WIDTH_LEN-1:0] oCount
);

    localparam int                 DRAIN_W    = $clog2(ACC_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(ACC_LAT);

    seq_state_e           state_q, state_d;
    logic [WIDTH_LEN-1:0] count_q, count_d;
    logic                 init_pend_q, init_pend_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 in_run;
    logic                 consume;

    // Abort wins over a simultaneous handshake, so that term never reaches
    // the accumulator nor the count.
    assign in_run          = (state_q == RUN);
    assign term.oTermReady = in_run;
    assign consume         = term.iTermValid & in_run & ~iAbort;

    assign oAccValid = consume & ~term.iTermZero;
    assign oAccSub   = oAccValid & term.iTermNeg;
    assign oAccData  = oAccValid ? term.iTermData : '0;
    assign oBusy     = (state_q != IDLE);
    assign oCount    = count_q;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            init_pend_q <= 1'b0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            init_pend_q <= init_pend_d;
            drain_q     <= drain_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        init_pend_d = init_pend_q;
        drain_d     = drain_q;
        oAccInit    = 1'b0;
        oDone       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    count_d = iLen;
                    if (iLen == '0) begin
                        // Empty frame: clear the accumulator now and just wait out its latency.
                        oAccInit    = 1'b1;
                        init_pend_d = 1'b0;
                        drain_d     = DRAIN_LOAD;
                        state_d     = DRAIN;
                    end else begin
                        init_pend_d = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                oAccInit = init_pend_q;
                if (consume) begin
                    init_pend_d = 1'b0;
                    count_d     = count_q - 1'b1;
                    if (count_q == WIDTH_LEN'(1)) begin
                        drain_d = DRAIN_LOAD;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - 1'b1;
                if (drain_q == DRAIN_W'(1)) begin
                    oDone   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (iAbort && (state_q != IDLE)) begin
            state_d     = IDLE;
            count_d     = '0;
            init_pend_d = 1'b0;
            drain_d     = '0;
            oDone       = 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_term_sequencer.sv
// Randomised bench for acc_term_sequencer with a behavioural accumulator
// and a done/result scoreboard.
module tb_acc_term_sequencer;

    logic        iCLK;
    logic        iRST_n;
    logic        iStart;
    logic [9:0]  iLen;
    logic        iAbort;
    logic        oBusy;
    logic        oAccInit;
    logic        oAccValid;
    logic        oAccSub;
    logic [15:0] oAccData;
    logic        oDone;
    logic [9:0]  oCount;

    acc_term_sequencer_if #(.WIDTH_IN(16)) term_if ();

    acc_term_sequencer #(
        .WIDTH_IN (16),
        .WIDTH_LEN(10),
        .ACC_LAT  (2)
    ) dut (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .iStart   (iStart),
        .iLen     (iLen),
        .iAbort   (iAbort),
        .oBusy    (oBusy),
        .term     (term_if),
        .oAccInit (oAccInit),
        .oAccValid(oAccValid),
        .oAccSub  (oAccSub),
        .oAccData (oAccData),
        .oDone    (oDone),
        .oCount   (oCount)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_m    = 0;

    typedef struct {
        int sum;
        int done_cyc;
    } exp_t;
    exp_t sb_q[$];

    bit          q_v[$];
    logic [15:0] q_d[$];
    bit          q_n[$];
    bit          q_z[$];

    bit          exp_en   = 1'b0;
    bit          exp_full = 1'b0;
    logic        exp_busy, exp_ready, exp_init, exp_valid, exp_sub, exp_done;
    logic [15:0] exp_data;
    logic [9:0]  exp_count;

    logic        s_init, s_val, s_sub;
    logic [15:0] s_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int term_val(input logic sub, input logic [15:0] d);
        return sub ? -int'($signed(d)) : int'($signed(d));
    endfunction

    task automatic set_exp(input logic busy, input logic ready, input logic init, input logic valid,
                           input logic sub, input logic done, input logic [15:0] data,
                           input logic [9:0] count);
        exp_en    = 1'b1;
        exp_full  = 1'b1;
        exp_busy  = busy;
        exp_ready = ready;
        exp_init  = init;
        exp_valid = valid;
        exp_sub   = sub;
        exp_done  = done;
        exp_data  = data;
        exp_count = count;
    endtask

    task automatic random_terms();
        term_if.iTermValid = 1'($urandom);
        term_if.iTermData  = 16'($urandom);
        term_if.iTermNeg   = 1'($urandom);
        term_if.iTermZero  = 1'($urandom);
    endtask

    task automatic drive_terms(output logic v, output logic [15:0] d, output logic ng,
                               output logic zr, input int vpct);
        v = (q_v.size() != 0) ? q_v.pop_front() : ($urandom_range(0, 99) < vpct);
        if (v && q_d.size() != 0) begin
            d  = q_d.pop_front();
            ng = q_n.pop_front();
            zr = q_z.pop_front();
        end else begin
            d  = 16'($urandom);
            ng = 1'($urandom);
            zr = ($urandom_range(0, 4) == 0);
        end
        term_if.iTermValid = v;
        term_if.iTermData  = d;
        term_if.iTermNeg   = ng;
        term_if.iTermZero  = zr;
    endtask

    task automatic push_term(input logic [15:0] d, input bit ng, input bit zr);
        q_d.push_back(d);
        q_n.push_back(ng);
        q_z.push_back(zr);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(posedge iCLK); #1;
            iStart = 1'b0;
            iAbort = 1'b0;
            random_terms();
            set_exp(0, 0, 0, 0, 0, 0, '0, '0);
        end
    endtask

    // One frame of n terms; cut_at >= 0 aborts (or resets, if cut_rst)
    // once that many terms have been consumed.
    task automatic run_frame(input int n, input int vpct, input int cut_at, input bit cut_rst);
        int          sum;
        int          consumed;
        logic        v, ng, zr;
        logic [15:0] d;
        exp_t        e;
        sum      = 0;
        consumed = 0;

        @(posedge iCLK); #1;
        iStart = 1'b1;
        iLen   = 10'(n);
        iAbort = 1'b0;
        random_terms();
        set_exp(0, 0, (n == 0), 0, 0, 0, '0, '0);
        if (n == 0) begin
            e.sum      = 0;
            e.done_cyc = cyc + 2;
            sb_q.push_back(e);
        end

        while (consumed < n) begin
            @(posedge iCLK); #1;
            iStart = 1'($urandom);
            iLen   = 10'($urandom);
            if (consumed == cut_at) begin
                random_terms();
                term_if.iTermValid = 1'b1;
                if (cut_rst) begin
                    exp_en = 1'b0;
                    iStart = 1'b0;
                    check("pre_reset_count", 32'(oCount), 32'(n - consumed));
                    #2 iRST_n = 1'b0;
                    #1;
                    check("rst_busy",  32'(oBusy), 0);
                    check("rst_ready", 32'(term_if.oTermReady), 0);
                    check("rst_init",  32'(oAccInit), 0);
                    check("rst_valid", 32'(oAccValid), 0);
                    check("rst_sub",   32'(oAccSub), 0);
                    check("rst_data",  32'(oAccData), 0);
                    check("rst_done",  32'(oDone), 0);
                    check("rst_count", 32'(oCount), 0);
                    @(posedge iCLK); #3;
                    iRST_n = 1'b1;
                    term_if.iTermValid = 1'b0;
                end else begin
                    iAbort    = 1'b1;
                    exp_en    = 1'b1;
                    exp_full  = 1'b0;
                    exp_busy  = 1'b1;
                    exp_ready = 1'b1;
                    @(posedge iCLK); #1;
                    iAbort = 1'b0;
                    iStart = 1'b0;
                    term_if.iTermValid = 1'b0;
                    set_exp(0, 0, 0, 0, 0, 0, '0, '0);
                end
                return;
            end
            drive_terms(v, d, ng, zr, vpct);
            set_exp(1, 1, (consumed == 0), v & !zr, v & !zr & ng, 0,
                    (v && !zr) ? d : 16'h0, 10'(n - consumed));
            if (v) begin
                consumed++;
                if (!zr) sum += term_val(ng, d);
                if (consumed == n) begin
                    e.sum      = sum;
                    e.done_cyc = cyc + 2;
                    sb_q.push_back(e);
                end
            end
        end

        for (int k = 0; k < 2; k++) begin
            @(posedge iCLK); #1;
            iStart = 1'($urandom);
            iLen   = 10'($urandom);
            random_terms();
            set_exp(1, 0, 0, 0, 0, (k == 1), '0, '0);
        end
    endtask

    always @(posedge iCLK) cyc <= cyc + 1;

    // Behavioural stand-in for acc_term_unit: init loads (term or zero), valid adds.
    always @(posedge iCLK) begin
        if (s_init)     acc_m <= s_val ? term_val(s_sub, s_data) : 0;
        else if (s_val) acc_m <= acc_m + term_val(s_sub, s_data);
    end

    always @(negedge iCLK) begin
        if (iRST_n) begin
            s_init <= oAccInit;
            s_val  <= oAccValid;
            s_sub  <= oAccSub;
            s_data <= oAccData;
            if (exp_en) begin
                check("busy",  32'(oBusy), 32'(exp_busy));
                check("ready", 32'(term_if.oTermReady), 32'(exp_ready));
                if (exp_full) begin
                    check("acc_init",  32'(oAccInit), 32'(exp_init));
                    check("acc_valid", 32'(oAccValid), 32'(exp_valid));
                    check("acc_sub",   32'(oAccSub), 32'(exp_sub));
                    check("acc_data",  32'(oAccData), 32'(exp_data));
                    check("count",     32'(oCount), 32'(exp_count));
                    check("done_flag", 32'(oDone), 32'(exp_done));
                end
            end
            if (oDone) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(oDone), 0);
                end else begin
                    check("result",     32'(acc_m), 32'(sb_q[0].sum));
                    check("done_cycle", 32'(cyc), 32'(sb_q[0].done_cyc));
                    void'(sb_q.pop_front());
                end
            end
        end else begin
            s_init <= 1'b0;
            s_val  <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        iRST_n = 1'b0;
        iStart = 1'b0;
        iLen   = '0;
        iAbort = 1'b0;
        term_if.iTermValid = 1'b0;
        term_if.iTermData  = '0;
        term_if.iTermNeg   = 1'b0;
        term_if.iTermZero  = 1'b0;
        #3;
        check("reset_busy",  32'(oBusy), 0);
        check("reset_ready", 32'(term_if.oTermReady), 0);
        check("reset_init",  32'(oAccInit), 0);
        check("reset_valid", 32'(oAccValid), 0);
        check("reset_data",  32'(oAccData), 0);
        check("reset_done",  32'(oDone), 0);
        check("reset_count", 32'(oCount), 0);
        #9 iRST_n = 1'b1;
        idle_cycles(2);

        // 5 + 7 - 3 = 9, continuous valid
        repeat (3) q_v.push_back(1'b1);
        push_term(16'd5, 0, 0);
        push_term(16'd7, 0, 0);
        push_term(16'd3, 1, 0);
        run_frame(3, 100, -1, 0);

        // Gapped valid, 1+2+3+4 = 10
        foreach (q_v[i]) q_v.delete(i);
        q_v = '{1, 0, 0, 1, 1, 0, 1};
        push_term(16'd1, 0, 0);
        push_term(16'd2, 0, 0);
        push_term(16'd3, 0, 0);
        push_term(16'd4, 0, 0);
        run_frame(4, 100, -1, 0);

        // Zero-weight middle term: 6 + 6 = 12
        repeat (3) q_v.push_back(1'b1);
        push_term(16'd6, 0, 0);
        push_term(16'd100, 0, 1);
        push_term(16'd6, 0, 0);
        run_frame(3, 100, -1, 0);

        // Leave 0x7FFF in the accumulator, then an empty frame must read 0
        q_v.push_back(1'b1);
        push_term(16'h7FFF, 0, 0);
        run_frame(1, 100, -1, 0);
        run_frame(0, 100, -1, 0);

        // Abort after 2 terms, then 1 + 1 = 2
        run_frame(5, 100, 2, 0);
        repeat (2) q_v.push_back(1'b1);
        push_term(16'd1, 0, 0);
        push_term(16'd1, 0, 0);
        run_frame(2, 100, -1, 0);

        // Reset with 3 terms remaining, then a single term of 8
        run_frame(5, 100, 2, 1);
        idle_cycles(1);
        q_v.push_back(1'b1);
        push_term(16'd8, 0, 0);
        run_frame(1, 100, -1, 0);

        for (int f = 0; f < 25; f++) begin
            int n;
            int cut;
            n   = $urandom_range(0, 12);
            cut = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            run_frame(n, $urandom_range(20, 100), cut, 0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        // Maximum term count
        run_frame(1023, 100, -1, 0);

        idle_cycles(4);
        exp_en = 1'b0;
        check("pending_done", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
